// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C byte engine and the EEPROM
// controller that sequences it (command encoding, engine states, device addresses).
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2,
        CMD_STOP  = 2'd3
    } i2c_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BIT   = 2'd2,
        ST_STOP  = 2'd3
    } i2c_state_t;

    // EEPROM device address with R/W bit, used by the upstream controller
    localparam logic [7:0] I2C_WR_ADDR = 8'hA0;
    localparam logic [7:0] I2C_RD_ADDR = 8'hA1;

    // Index of the ninth (acknowledge) slot within a byte transfer
    localparam logic [3:0] I2C_ACK_SLOT = 4'd8;

endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: divides the system clock into SCL quarter-periods of CLK_DIV
// cycles. tick is high on the last cycle of each quarter. While hold is high the
// count is pinned at 0, which is how a slave stretching SCL delays the quarter.
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic hold,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    logic [15:0] cnt;

    // Quarter counter: restarts whenever the engine is idle or the quarter ends
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= 16'd0;
        end else if (hold) begin
            cnt <= 16'd0;
        end else if (cnt == LAST) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign tick = run && !hold && (cnt == LAST);

endmodule

// File: rtl/i2c_byte_engine.sv
// i2c_byte_engine: bit/byte-level I2C master. Executes one START, WRITE, READ or
// STOP command at a time and drives SCL/SDA through registered open-drain enables.
// Optional build macro I2C_CLOCK_STRETCH_EN: when defined, a slave holding SCL low
// during a released-SCL quarter stalls the quarter counter; otherwise scl_i is unused.
module i2c_byte_engine
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  i2c_cmd_t   cmd,
    input  logic [7:0] tx_data,
    input  logic       ack_tx,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       ack_rx,
    output logic       bus_active,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);

    i2c_state_t state;
    i2c_cmd_t   op;
    logic [1:0] q;
    logic [3:0] bit_cnt;
    logic [6:0] tx_sh;
    logic [7:0] rx_sh;
    logic       ack_tx_r;
    logic       ack_smp;
    logic       tick;
    logic       run;
    logic       stretch_hold;

    assign run       = (state != ST_IDLE);
    assign cmd_ready = (state == ST_IDLE);

`ifdef I2C_CLOCK_STRETCH_EN
    // Every q2 has SCL released, so a low readback there means the slave is stretching
    assign stretch_hold = run && (q == 2'd2) && !scl_i;
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign stretch_hold = 1'b0;
`endif

    i2c_quarter_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .hold (stretch_hold),
        .tick (tick)
    );

    // Command FSM: line enables are loaded one quarter ahead so each quarter sees stable pins
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op         <= CMD_START;
            q          <= 2'd0;
            bit_cnt    <= 4'd0;
            tx_sh      <= 7'd0;
            rx_sh      <= 8'd0;
            ack_tx_r   <= 1'b1;
            ack_smp    <= 1'b1;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
            done       <= 1'b0;
            rx_data    <= 8'h00;
            ack_rx     <= 1'b1;
            bus_active <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        q        <= 2'd0;
                        bit_cnt  <= 4'd0;
                        op       <= cmd;
                        tx_sh    <= tx_data[6:0];
                        ack_tx_r <= ack_tx;
                        scl_oe   <= 1'b1;
                        case (cmd)
                            CMD_START: begin
                                state  <= ST_START;
                                sda_oe <= 1'b0;
                            end
                            CMD_STOP: begin
                                state  <= ST_STOP;
                                sda_oe <= 1'b1;
                            end
                            CMD_WRITE: begin
                                state  <= ST_BIT;
                                sda_oe <= ~tx_data[7];
                            end
                            default: begin
                                state  <= ST_BIT;
                                sda_oe <= 1'b0;
                            end
                        endcase
                    end
                end

                ST_START: begin
                    if (tick) begin
                        case (q)
                            2'd0: begin
                                q      <= 2'd1;
                                scl_oe <= 1'b0;
                            end
                            2'd1: begin
                                q      <= 2'd2;
                                sda_oe <= 1'b1;
                            end
                            2'd2: begin
                                q      <= 2'd3;
                                scl_oe <= 1'b1;
                            end
                            default: begin
                                state      <= ST_IDLE;
                                q          <= 2'd0;
                                done       <= 1'b1;
                                bus_active <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_BIT: begin
                    if (tick) begin
                        case (q)
                            2'd0: begin
                                q <= 2'd1;
                            end
                            2'd1: begin
                                q      <= 2'd2;
                                scl_oe <= 1'b0;
                            end
                            2'd2: begin
                                q <= 2'd3;
                                if (bit_cnt == I2C_ACK_SLOT) begin
                                    ack_smp <= sda_i;
                                end else begin
                                    rx_sh <= {rx_sh[6:0], sda_i};
                                end
                            end
                            default: begin
                                scl_oe <= 1'b1;
                                if (bit_cnt == I2C_ACK_SLOT) begin
                                    state <= ST_IDLE;
                                    q     <= 2'd0;
                                    done  <= 1'b1;
                                    if (op == CMD_READ) begin
                                        rx_data <= rx_sh;
                                    end else begin
                                        ack_rx <= ack_smp;
                                    end
                                end else begin
                                    q       <= 2'd0;
                                    bit_cnt <= bit_cnt + 4'd1;
                                    tx_sh   <= {tx_sh[5:0], 1'b0};
                                    if (bit_cnt == I2C_ACK_SLOT - 4'd1) begin
                                        sda_oe <= (op == CMD_READ) ? ~ack_tx_r : 1'b0;
                                    end else begin
                                        sda_oe <= (op == CMD_READ) ? 1'b0 : ~tx_sh[6];
                                    end
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    if (tick) begin
                        case (q)
                            2'd0: begin
                                q      <= 2'd1;
                                scl_oe <= 1'b0;
                            end
                            2'd1: begin
                                q <= 2'd2;
                            end
                            2'd2: begin
                                q      <= 2'd3;
                                sda_oe <= 1'b0;
                            end
                            default: begin
                                state      <= ST_IDLE;
                                q          <= 2'd0;
                                done       <= 1'b1;
                                bus_active <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_byte_engine.sv
// tb_i2c_byte_engine: directed test of i2c_byte_engine with CLK_DIV=4 and a small
// open-drain slave model. The stretch step expects extra latency only when the
// design is built with I2C_CLOCK_STRETCH_EN.
module tb_i2c_byte_engine;
    import i2c_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int LAT_SS  = 4 * CLK_DIV;
    localparam int LAT_BYTE = 36 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    i2c_cmd_t   cmd = CMD_START;
    logic [7:0] tx_data = 8'h00;
    logic       ack_tx = 1'b0;
    logic       cmd_ready, done, ack_rx, bus_active, scl_oe, sda_oe, scl_i, sda_i;
    logic [7:0] rx_data;

    int total = 0;
    int bad   = 0;

    int         rises = 0;
    int         base_rises = 0;
    int         slot;
    logic [8:0] cap = 9'd0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    logic       prev_scl_oe = 1'b0;
    logic       prev_sda_oe = 1'b0;

    logic       slave_en = 1'b0;
    logic [8:0] slave_pat = 9'h1FF;
    logic       slave_sda_low;
    logic       slave_scl_hold;
    logic       stretch_en = 1'b0;
    int         held = 0;
    int         hold_target = 0;

    int lat;
    int s0;
    int p0;

    always #5 clk = ~clk;

    i2c_byte_engine #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .tx_data    (tx_data),
        .ack_tx     (ack_tx),
        .done       (done),
        .rx_data    (rx_data),
        .ack_rx     (ack_rx),
        .bus_active (bus_active),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .scl_i      (scl_i),
        .sda_i      (sda_i)
    );

    // Open-drain bus: a line reads high only when nobody pulls it low
    assign sda_i = !sda_oe && !slave_sda_low;
    assign scl_i = !scl_oe && !slave_scl_hold;

    // Slot index of the current bit: SCL releases seen, minus one while SCL is high
    always_comb begin
        slot = (rises - base_rises) - (scl_oe ? 0 : 1);
    end

    // Slave data/ack driver, slot 0 is the MSB and slot 8 the ack slot
    always_comb begin
        slave_sda_low = 1'b0;
        if (slave_en && slot >= 0 && slot < 9) begin
            slave_sda_low = ~slave_pat[8 - slot];
        end
    end

    assign slave_scl_hold = stretch_en && ((rises - base_rises) == 4) && !scl_oe && (held < hold_target);

    // Count cycles for which the slave stretches SCL
    always @(posedge clk) begin
        if (slave_scl_hold) held <= held + 1;
    end

    // Capture what the master drives on SDA at every SCL release
    always @(negedge scl_oe) begin
        cap   = {cap[7:0], ~sda_oe};
        rises = rises + 1;
    end

    // Detect SDA edges while SCL stays released: falling = START, rising = STOP
    always @(negedge clk) begin
        if (!prev_scl_oe && !scl_oe) begin
            if (!prev_sda_oe && sda_oe) start_cnt <= start_cnt + 1;
            if (prev_sda_oe && !sda_oe) stop_cnt <= stop_cnt + 1;
        end
        prev_scl_oe <= scl_oe;
        prev_sda_oe <= sda_oe;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input i2c_cmd_t c, input logic [7:0] d, input logic a);
        int n;
        base_rises = rises;
        cmd       = c;
        tx_data   = d;
        ack_tx    = a;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("ready_before_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitDone(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 3000);
    endtask

    initial begin
        $display("[TB] start, CLK_DIV=%0d", CLK_DIV);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_scl_oe", 32'(scl_oe), 32'd0);
        checkOutput("rst_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_rx_data", 32'(rx_data), 32'h00);
        checkOutput("rst_ack_rx", 32'(ack_rx), 32'd1);
        checkOutput("rst_bus_active", 32'(bus_active), 32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // START from idle bus
        s0 = start_cnt;
        applyStimulus(CMD_START, 8'h00, 1'b0);
        waitDone(lat);
        checkOutput("start_latency", 32'(lat), 32'(LAT_SS));
        checkOutput("start_ready_at_done", 32'(cmd_ready), 32'd1);
        checkOutput("start_bus_active", 32'(bus_active), 32'd1);
        checkOutput("start_scl_held_low", 32'(scl_oe), 32'd1);
        checkOutput("start_condition_seen", 32'(start_cnt - s0), 32'd1);

        // WRITE 0xA0, slave acks
        s0 = start_cnt;
        p0 = stop_cnt;
        slave_en  = 1'b1;
        slave_pat = 9'b1_1111_1110;
        applyStimulus(CMD_WRITE, I2C_WR_ADDR, 1'b0);
        waitDone(lat);
        slave_en = 1'b0;
        checkOutput("wr_a0_latency", 32'(lat), 32'(LAT_BYTE));
        checkOutput("wr_a0_sda_bits", 32'(cap), 32'h141);
        checkOutput("wr_a0_ack_rx", 32'(ack_rx), 32'd0);
        checkOutput("wr_a0_no_spurious_start", 32'(start_cnt - s0), 32'd0);
        checkOutput("wr_a0_no_spurious_stop", 32'(stop_cnt - p0), 32'd0);
        checkOutput("wr_a0_scl_held_low", 32'(scl_oe), 32'd1);

        // WRITE 0xA1, no slave
        applyStimulus(CMD_WRITE, I2C_RD_ADDR, 1'b0);
        waitDone(lat);
        checkOutput("wr_a1_sda_bits", 32'(cap), 32'h143);
        checkOutput("wr_a1_ack_rx", 32'(ack_rx), 32'd1);

        // Repeated START while bus is active
        s0 = start_cnt;
        applyStimulus(CMD_START, 8'h00, 1'b0);
        waitDone(lat);
        checkOutput("rstart_latency", 32'(lat), 32'(LAT_SS));
        checkOutput("rstart_condition_seen", 32'(start_cnt - s0), 32'd1);

        // READ 0x5A with NACK
        slave_en  = 1'b1;
        slave_pat = {8'h5A, 1'b1};
        applyStimulus(CMD_READ, 8'h00, 1'b1);
        waitDone(lat);
        slave_en = 1'b0;
        checkOutput("rd_5a_latency", 32'(lat), 32'(LAT_BYTE));
        checkOutput("rd_5a_rx_data", 32'(rx_data), 32'h5A);
        checkOutput("rd_5a_master_sda", 32'(cap), 32'h1FF);

        // READ 0xC3 with ACK, issued back-to-back on the done cycle
        slave_en  = 1'b1;
        slave_pat = {8'hC3, 1'b1};
        applyStimulus(CMD_READ, 8'h00, 1'b0);
        waitDone(lat);
        slave_en = 1'b0;
        checkOutput("rd_c3_rx_data", 32'(rx_data), 32'hC3);
        checkOutput("rd_c3_master_sda", 32'(cap), 32'h1FE);
        checkOutput("rd_c3_ack_rx_unchanged", 32'(ack_rx), 32'd1);

        // STOP
        p0 = stop_cnt;
        applyStimulus(CMD_STOP, 8'h00, 1'b0);
        waitDone(lat);
        checkOutput("stop_latency", 32'(lat), 32'(LAT_SS));
        checkOutput("stop_condition_seen", 32'(stop_cnt - p0), 32'd1);
        checkOutput("stop_bus_active", 32'(bus_active), 32'd0);
        checkOutput("stop_scl_released", 32'(scl_oe), 32'd0);
        checkOutput("stop_sda_released", 32'(sda_oe), 32'd0);

        // READ with the slave holding SCL low for 20 cycles in slot 3
        applyStimulus(CMD_START, 8'h00, 1'b0);
        waitDone(lat);
        slave_en    = 1'b1;
        slave_pat   = {8'h3C, 1'b1};
        stretch_en  = 1'b1;
        hold_target = 20;
        applyStimulus(CMD_READ, 8'h00, 1'b0);
        waitDone(lat);
        slave_en   = 1'b0;
        stretch_en = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
        checkOutput("stretch_latency", 32'(lat), 32'(LAT_BYTE + 20));
`else
        checkOutput("stretch_ignored_latency", 32'(lat), 32'(LAT_BYTE));
`endif
        checkOutput("stretch_rx_data", 32'(rx_data), 32'h3C);
        applyStimulus(CMD_STOP, 8'h00, 1'b0);
        waitDone(lat);

        // Reset in the middle of a WRITE
        applyStimulus(CMD_WRITE, 8'hA0, 1'b0);
        repeat (49) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_scl_oe", 32'(scl_oe), 32'd0);
        checkOutput("abort_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_rx_data", 32'(rx_data), 32'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(CMD_START, 8'h00, 1'b0);
        waitDone(lat);
        checkOutput("post_abort_start_latency", 32'(lat), 32'(LAT_SS));
        checkOutput("post_abort_bus_active", 32'(bus_active), 32'd1);
        applyStimulus(CMD_STOP, 8'h00, 1'b0);
        waitDone(lat);
        checkOutput("post_abort_stop_bus_active", 32'(bus_active), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_byte_engine.md
# i2c_byte_engine

Bit/byte-level I2C master engine that sits directly downstream of the EEPROM memory controller and drives the DE0-Nano I2C_SCLK/I2C_SDAT pins through open-drain enables. The controller issues one command at a time (START, WRITE byte, READ byte, STOP). The engine generates SCL from the system clock, shifts data MSB first, and returns received data and ACK status. It owns all pin timing, so the controller only sequences transactions such as address 0xA0/0xA1, word address and data.

## Interface
- CLK_DIV, 125: system-clock cycles per SCL quarter-period; SCL period = 4*CLK_DIV cycles (50 MHz -> 100 kHz). Legal range 2..65535.
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
- cmd  in  2  i2c_cmd_t: CMD_START, CMD_WRITE, CMD_READ, CMD_STOP
- tx_data  in  8  byte for CMD_WRITE, captured at accept
- ack_tx  in  1  bit sent in ACK slot of CMD_READ (0 = ACK, 1 = NACK), captured at accept
- done  out  1  one-cycle pulse when a command completes
- rx_data  out  8  byte received by last CMD_READ, valid from done onward
- ack_rx  out  1  ACK-slot value sampled on last CMD_WRITE (0 = slave ACKed)
- bus_active  out  1  high from START completion to STOP completion
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- scl_i, sda_i  in  1 each  pin readback, already synchronised upstream

## Operation
- States: IDLE, START, BIT, STOP. A quarter counter (0..CLK_DIV-1) and a phase counter q (0..3) advance in all non-IDLE states.
- START: q0 SCL low, SDA released; q1 SCL released; q2 SDA pulled low with SCL high; q3 SCL pulled low. This sequence also serves as a repeated START when bus_active is 1. bus_active goes to 1 at done.
- BIT, run 9 times (bits 7..0, then ACK slot): q0–q1 SCL low, SDA set to the bit value. For WRITE the bit is tx bit, and the ACK slot is released. For READ data slots are released, and the ACK slot drives ack_tx. q2–q3 SCL released. sda_i is sampled on the last cycle of q2.
- WRITE ACK-slot sample -> ack_rx. READ data samples shift into rx_data MSB first; rx_data and ack_rx update only at done.
- STOP: q0 SCL low, SDA low; q1 SCL released; q2 SDA held low; q3 SDA released. bus_active goes to 0 at done.
- Every command returns to IDLE with done=1 for one cycle. Lines stay in their last state: after START and BIT, SCL is held low; after STOP, both lines are released.
- Commands are executed as given, with no protocol checking. WRITE or READ without a prior START still clocks bits.
- cmd_valid while cmd_ready=0 is ignored; the requester holds it.
- Reset values: scl_oe 0, sda_oe 0, done 0, rx_data 0x00, ack_rx 1, bus_active 0, state IDLE, so cmd_ready is 1. Reset mid-command aborts immediately and releases both lines on the next cycle. A partial byte is discarded.

## Timing
- Accept to done: START and STOP take 4*CLK_DIV cycles. WRITE and READ take 36*CLK_DIV cycles, with no clock stretching.
- done and cmd_ready rise in the same cycle, so a new command can be accepted on the done cycle, back-to-back.
- scl_oe/sda_oe are registered. SDA changes only while SCL is low, except the START and STOP edges.

## Configuration
- I2C_CLOCK_STRETCH_EN defined: in any q2 where SCL is released, the quarter counter holds at 0 until scl_i reads 1. Latency grows by the stretch duration; no timeout.
- Undefined: scl_i is ignored and timing is fixed. The port remains in the interface.

## Structure
- Package i2c_pkg: i2c_cmd_t enum, engine state enum, I2C_WR_ADDR = 8'hA0 and I2C_RD_ADDR = 8'hA1 for the controller.
- Sub-module i2c_quarter_tick: CLK_DIV counter with hold input; emits a tick on the last cycle of each quarter.

## Test plan
- CLK_DIV=4, START then STOP -> done after 16 cycles each; SDA falls while SCL is high, then SDA rises while SCL is high; bus_active goes 1 then 0.
- WRITE 0xA0, slave model ACKs -> SDA bits 1,0,1,0,0,0,0,0 on successive SCL highs; ack_rx=0; done 144 cycles after accept.
- WRITE 0xA1 with no slave driving -> ack_rx=1.
- READ, slave drives 0x5A, ack_tx=1 -> rx_data=0x5A; SDA released in the ACK slot.
- rst asserted at cycle 50 of a WRITE -> scl_oe=sda_oe=0 and cmd_ready=1 on the next cycle; the next START completes normally.
- With I2C_CLOCK_STRETCH_EN, slave holds SCL low 20 extra cycles on bit 3 -> done delayed exactly 20 cycles; data intact.
